// File: rtl/pc_unit.sv
// Program counter and next-PC sequencer: drives fetch address to imem, picks seq/branch/jump/jr targets.
// Latency: a redirect taken on an accept edge is visible on pc one cycle later; pc_plus4 is combinational.
// Backpressure: pc and all redirect state hold while stall=1 or imem_ready=0 (no accept).
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        addr_exc,
  output logic [31:0] exc_epc,
  output logic [1:0]  run_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_JR     = 2'b11;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] epc_q;
  logic [31:0] epc_d;
  logic        exc_q;
  logic        exc_d;
  logic        accept;
  logic        jr_misaligned;
  logic [31:0] jump_target;

  // Fetch request is only offered while running and not stalled; the
  // handshake completes when imem also signals ready.
  assign if_valid      = (state_q == ST_RUN) & ~stall;
  assign accept        = if_valid & imem_ready;
  assign pc_plus4      = pc_q + 32'd4;
  assign jr_misaligned = (npc_sel == SEL_JR) && (jr_target[1:0] != 2'b00);
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

  assign pc        = pc_q;
  assign addr_exc  = exc_q;
  assign exc_epc   = epc_q;
  assign run_state = state_q;

  // Run-state FSM: one BOOT cycle, then RUN until a halt on an accepted fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (accept && halt) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  // Next-PC selection on accept, highest priority first; the exception
  // pulse defaults low so it lasts exactly one cycle.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    exc_d = 1'b0;
    if (accept) begin
      if (jr_misaligned) begin
        pc_d  = EXC_PC;
        epc_d = pc_q;
        exc_d = 1'b1;
      end else begin
        case (npc_sel)
          SEL_JR:     pc_d = jr_target;
          SEL_JUMP:   pc_d = jump_target;
          SEL_BRANCH: pc_d = br_taken ? br_target : pc_plus4;
          SEL_SEQ:    pc_d = pc_plus4;
          default:    pc_d = pc_plus4;
        endcase
      end
    end
  end

  // State registers; reset wins over everything, including a pending pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
    end
  end

endmodule
